// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: latch and handshake controller for one pipeline stage.
// It holds the stage's valid bit and opaque payload, counts down extra cycles
// for multi-cycle operations, reports handshake status to the neighbouring
// stages and to hazard detection, and keeps a saturating stall-cycle counter.
module pipe_stage_ctrl #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 4,
  parameter int PERF_W = 32
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              prev_valid_out,
  input  logic [DATA_W-1:0] payload_in,
  input  logic [CNT_W-1:0]  op_cycles,
  input  logic              write_en,
  input  logic              flush,
  input  logic              next_allow_in,
  output logic              allow_in,
  output logic              valid_out,
  output logic              stage_valid,
  output logic              busy,
  output logic [DATA_W-1:0] payload_out,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  // Saturating increment: the stall counter sticks at all-ones instead of
  // wrapping back to zero, so a long stall never looks like a short one.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    logic [PERF_W-1:0] r;
    if (&v) r = v;
    else    r = v + PERF_ONE;
    return r;
  endfunction

  // Stage state
  logic              valid_p0;
  logic [DATA_W-1:0] payload_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic [PERF_W-1:0] perf_p0;

  // Handshake terms, derived from state plus the live control inputs
  logic ready_go;
  logic advance;
  logic held;

  // Combinational handshake: no registered delay between state and status.
  always_comb begin
    ready_go     = write_en && (cnt_p0 == '0);
    advance      = ready_go && next_allow_in;
    valid_out    = valid_p0 && ready_go;
    allow_in     = !valid_p0 || advance;
    busy         = valid_p0 && (cnt_p0 != '0);
    held         = valid_p0 && !advance && !flush;
    stage_valid  = valid_p0;
    payload_out  = payload_p0;
    stall_cycles = perf_p0;
  end

  // Valid bit and multi-cycle counter: flush beats accept, accept beats
  // countdown. The countdown ignores write_en/next_allow_in so a stalled
  // multi-cycle op still finishes its work while it waits.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      valid_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else if (flush) begin
      valid_p0 <= 1'b0;
      cnt_p0   <= '0;
    end else if (allow_in) begin
      valid_p0 <= prev_valid_out;
      if (prev_valid_out) cnt_p0 <= op_cycles;
    end else if (valid_p0 && (cnt_p0 != '0)) begin
      cnt_p0 <= cnt_p0 - CNT_ONE;
    end
  end

  // Payload latch: loads only on a real accept; a flush leaves the old
  // payload visible so debug can still see what was killed.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      payload_p0 <= '0;
    end else if (!flush && allow_in && prev_valid_out) begin
      payload_p0 <= payload_in;
    end
  end

  // Stall counter: one tick per cycle a live instruction fails to leave,
  // except on a flush cycle where the instruction is being discarded.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      perf_p0 <= '0;
    end else if (held) begin
      perf_p0 <= sat_inc(perf_p0);
    end
  end

endmodule
